// File: rtl/clk_ctrl.sv
// clk_ctrl: rate controller for the divided-clock datapath.
//
// A free-running divide counter feeds a tap selected by the active factor. The
// factor can be stepped up or down with pushbutton-style level inputs. Every
// rate change goes through a drain/hold sequence, so the divided output never
// produces a shortened high pulse.
//
// Optional feature macro: CLK_CTRL_SYNC_EN. When defined, up/dn/pause each
// pass through a 2-flop synchronizer before use. When undefined, the inputs
// must already be synchronous to clk_ctrl_fsys.
//
// Parameters:
//   SIZE        divide counter width (>= FACTOR_MAX)
//   FACTOR_MIN  lowest legal factor (>= 1)
//   FACTOR_MAX  highest legal factor (<= 31)
//   FACTOR_RST  factor loaded at reset
//
// Ports:
//   clk_ctrl_fsys    in   system clock, rising edge
//   clk_ctrl_rst     in   asynchronous active-low reset
//   clk_ctrl_up      in   rising edge requests factor+1 (slower)
//   clk_ctrl_dn      in   rising edge requests factor-1 (faster)
//   clk_ctrl_pause   in   high freezes the divide counter
//   clk_ctrl_factor  out  active factor
//   clk_ctrl_out     out  registered divided clock, period 2^factor
//   clk_ctrl_tick    out  one-cycle pulse on each clk_ctrl_out rising edge
//   clk_ctrl_busy    out  high while a factor change is in progress

module clk_ctrl #(
  parameter int unsigned SIZE       = 32,
  parameter int unsigned FACTOR_MIN = 1,
  parameter int unsigned FACTOR_MAX = 26,
  parameter int unsigned FACTOR_RST = 4
) (
  input  logic       clk_ctrl_fsys,
  input  logic       clk_ctrl_rst,
  input  logic       clk_ctrl_up,
  input  logic       clk_ctrl_dn,
  input  logic       clk_ctrl_pause,
  output logic [4:0] clk_ctrl_factor,
  output logic       clk_ctrl_out,
  output logic       clk_ctrl_tick,
  output logic       clk_ctrl_busy
);

  localparam logic [4:0] FMin = 5'(FACTOR_MIN);
  localparam logic [4:0] FMax = 5'(FACTOR_MAX);
  localparam logic [4:0] FRst = 5'(FACTOR_RST);
  localparam logic [SIZE-1:0] CntOne = {{(SIZE-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StHold
  } state_e;

  // Conditioned inputs
  logic up_s, dn_s, pause_s;

`ifdef CLK_CTRL_SYNC_EN
  // Bit order: {pause, dn, up}
  logic [2:0] sync1_q, sync2_q;

  always_ff @(posedge clk_ctrl_fsys or negedge clk_ctrl_rst) begin
    if (!clk_ctrl_rst) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
    end else begin
      sync1_q <= {clk_ctrl_pause, clk_ctrl_dn, clk_ctrl_up};
      sync2_q <= sync1_q;
    end
  end

  assign up_s    = sync2_q[0];
  assign dn_s    = sync2_q[1];
  assign pause_s = sync2_q[2];
`else
  assign up_s    = clk_ctrl_up;
  assign dn_s    = clk_ctrl_dn;
  assign pause_s = clk_ctrl_pause;
`endif

  // Edge detect
  logic up_prev_q, dn_prev_q;
  logic up_req, dn_req;

  always_ff @(posedge clk_ctrl_fsys or negedge clk_ctrl_rst) begin
    if (!clk_ctrl_rst) begin
      up_prev_q <= 1'b0;
      dn_prev_q <= 1'b0;
    end else begin
      up_prev_q <= up_s;
      dn_prev_q <= dn_s;
    end
  end

  assign up_req = up_s & ~up_prev_q;
  assign dn_req = dn_s & ~dn_prev_q;

  // Divide counter
  logic [SIZE-1:0] cnt_q;

  always_ff @(posedge clk_ctrl_fsys or negedge clk_ctrl_rst) begin
    if (!clk_ctrl_rst) begin
      cnt_q <= '0;
    end else if (!pause_s) begin
      cnt_q <= cnt_q + CntOne;
    end
  end

  // Tap select: bit (cur-1) of the counter
  logic [4:0]      cur_q, cur_d;
  logic [4:0]      pend_q, pend_d;
  logic [4:0]      tap_idx;
  logic [SIZE-1:0] cnt_shift;
  logic            tap;

  assign tap_idx   = cur_q - 5'd1;
  assign cnt_shift = cnt_q >> tap_idx;
  assign tap       = cnt_shift[0];

  // Rate-change FSM
  state_e state_q, state_d;
  logic   out_q, out_d;
  logic   tick_q, tick_d;
  logic   busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    pend_d  = pend_q;
    busy_d  = busy_q;
    out_d   = tap;
    unique case (state_q)
      StIdle: begin
        // Simultaneous up and down requests cancel; requests at a limit are ignored.
        if (up_req && !dn_req && (cur_q < FMax)) begin
          pend_d  = cur_q + 5'd1;
          busy_d  = 1'b1;
          state_d = StDrain;
        end else if (dn_req && !up_req && (cur_q > FMin)) begin
          pend_d  = cur_q - 5'd1;
          busy_d  = 1'b1;
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Let the current high phase finish before switching taps.
        if (!tap) begin
          out_d   = 1'b0;
          cur_d   = pend_q;
          state_d = StHold;
        end
      end
      StHold: begin
        // Keep out low until the new tap is low, so the next high is a full one.
        out_d = 1'b0;
        if (!tap) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    tick_d = out_d & ~out_q;
  end

  always_ff @(posedge clk_ctrl_fsys or negedge clk_ctrl_rst) begin
    if (!clk_ctrl_rst) begin
      state_q <= StIdle;
      cur_q   <= FRst;
      pend_q  <= FRst;
      busy_q  <= 1'b0;
      out_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      out_q   <= out_d;
      tick_q  <= tick_d;
    end
  end

  assign clk_ctrl_factor = cur_q;
  assign clk_ctrl_out    = out_q;
  assign clk_ctrl_tick   = tick_q;
  assign clk_ctrl_busy   = busy_q;

endmodule

// File: tb/tb_clk_ctrl.sv
// Testbench for clk_ctrl. Expected tick times (posedge index since reset
// release) are pushed into a queue by the stimulus; a monitor pops one entry
// per observed tick. Level checks are made directly by the stimulus process.

module tb_clk_ctrl;

  logic       clk;
  logic       rst_n;
  logic       up, dn, pause;
  logic [4:0] factor;
  logic       out, tick, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int ecnt;
  int exp_q[$];
  bit mon_arm = 0;
  bit hi_chk  = 0;
  int hi_len  = 0;
  int hi_fac  = 0;
  logic out_prev_m = 1'b0;

  clk_ctrl dut (
    .clk_ctrl_fsys  (clk),
    .clk_ctrl_rst   (rst_n),
    .clk_ctrl_up    (up),
    .clk_ctrl_dn    (dn),
    .clk_ctrl_pause (pause),
    .clk_ctrl_factor(factor),
    .clk_ctrl_out   (out),
    .clk_ctrl_tick  (tick),
    .clk_ctrl_busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Posedge count since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", name, act, exp, ecnt, $time);
    end
  endtask

  // Monitor: tick timing scoreboard plus high-pulse length check.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tick && mon_arm) begin
        if (exp_q.size() == 0) begin
          check("tick_unexpected", ecnt, -1);
        end else begin
          check("tick_time", ecnt, exp_q.pop_front());
        end
      end
      if (hi_chk) begin
        if (out && !out_prev_m) begin
          hi_len = 1;
          hi_fac = int'(factor);
        end else if (out) begin
          hi_len++;
        end else if (out_prev_m) begin
          check("high_len", hi_len, 1 << (hi_fac - 1));
        end
      end
      out_prev_m = out;
    end else begin
      out_prev_m = 1'b0;
    end
  end

  task automatic at_edge(input int e);
    if (ecnt > e) check("at_edge_passed", ecnt, e);
    while (ecnt < e) @(negedge clk);
  endtask

  task automatic do_reset();
    mon_arm = 0;
    exp_q.delete();
    up = 0; dn = 0; pause = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    check("rst_factor", int'(factor), 4);
    check("rst_out", int'(out), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1;
  endtask

  // Pulse up or dn for one cycle and wait (bounded) for the change to finish.
  task automatic step(input bit is_up);
    int guard;
    @(negedge clk);
    if (is_up) up = 1; else dn = 1;
    @(negedge clk);
    up = 0; dn = 0;
    guard = 0;
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("step_busy_timeout", int'(guard < 200), 1);
  endtask

  initial begin
    logic o_prev;
    up = 0; dn = 0; pause = 0; rst_n = 0;

    // 1: steady state at factor 4
    do_reset();
    hi_chk = 1;
    exp_q.push_back(9); exp_q.push_back(25); exp_q.push_back(41); exp_q.push_back(57);
    mon_arm = 1;
    at_edge(8);  check("t1_out_e8", int'(out), 0);
    at_edge(9);  check("t1_out_e9", int'(out), 1);
    at_edge(10); check("t1_tick_e10", int'(tick), 0);
    at_edge(16); check("t1_out_e16", int'(out), 1);
    at_edge(17); check("t1_out_e17", int'(out), 0);
    check("t1_busy", int'(busy), 0);
    check("t1_factor", int'(factor), 4);
    at_edge(60); check("t1_queue_left", exp_q.size(), 0);

    // 2: single up at factor 4
    do_reset();
    exp_q.push_back(9); exp_q.push_back(25); exp_q.push_back(41);
    exp_q.push_back(81); exp_q.push_back(113);
    mon_arm = 1;
    at_edge(44); up = 1;
    at_edge(45); up = 0;
    check("t2_busy_start", int'(busy), 1);
    check("t2_factor_old", int'(factor), 4);
    at_edge(48); check("t2_factor_e48", int'(factor), 4);
    at_edge(49); check("t2_factor_e49", int'(factor), 5);
    check("t2_out_hold", int'(out), 0);
    at_edge(64); check("t2_busy_e64", int'(busy), 1);
    at_edge(65); check("t2_busy_e65", int'(busy), 0);
    at_edge(120); check("t2_queue_left", exp_q.size(), 0);

    // 3: down to the lower limit, then one more dn
    do_reset();
    step(0); step(0); step(0);
    check("t3_factor_min", int'(factor), 1);
    repeat (4) @(negedge clk);
    dn = 1;
    o_prev = out;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      dn = 0;
      check("t3_busy_limit", int'(busy), 0);
      check("t3_out_toggle", int'(out != o_prev), 1);
      o_prev = out;
    end
    check("t3_factor_still", int'(factor), 1);

    // 4: simultaneous up+dn ignored; second up while busy dropped
    do_reset();
    exp_q.push_back(9); exp_q.push_back(49); exp_q.push_back(81);
    mon_arm = 1;
    at_edge(2); up = 1; dn = 1;
    at_edge(3); up = 0; dn = 0;
    check("t4_both_busy_e3", int'(busy), 0);
    at_edge(4); check("t4_both_busy_e4", int'(busy), 0);
    check("t4_both_factor", int'(factor), 4);
    at_edge(10); up = 1;
    at_edge(11); up = 0;
    check("t4_busy", int'(busy), 1);
    at_edge(14); up = 1;
    at_edge(15); up = 0;
    at_edge(17); check("t4_factor_e17", int'(factor), 5);
    at_edge(33); check("t4_busy_e33", int'(busy), 0);
    at_edge(40); check("t4_factor_final", int'(factor), 5);
    at_edge(90); check("t4_queue_left", exp_q.size(), 0);

    // 5: reset asserted during HOLD
    do_reset();
    exp_q.push_back(9);
    mon_arm = 1;
    at_edge(10); up = 1;
    at_edge(11); up = 0;
    at_edge(20);
    check("t5_factor_hold", int'(factor), 5);
    check("t5_busy_hold", int'(busy), 1);
    check("t5_queue_left", exp_q.size(), 0);
    hi_chk = 0;
    #2 rst_n = 0;
    #1;
    check("t5_async_out", int'(out), 0);
    check("t5_async_tick", int'(tick), 0);
    check("t5_async_busy", int'(busy), 0);
    check("t5_async_factor", int'(factor), 4);
    do_reset();
    hi_chk = 1;
    exp_q.push_back(9); exp_q.push_back(25);
    mon_arm = 1;
    at_edge(30); check("t5_restart_queue", exp_q.size(), 0);

    // 6: pause for 40 cycles at factor 4
    do_reset();
    hi_chk = 0;
    exp_q.push_back(9); exp_q.push_back(65); exp_q.push_back(81);
    mon_arm = 1;
    at_edge(12); pause = 1;
    at_edge(14); check("t6_out_frozen_e14", int'(out), 1);
    at_edge(30); check("t6_out_frozen_e30", int'(out), 1);
    at_edge(52); check("t6_out_frozen_e52", int'(out), 1);
    pause = 0;
    at_edge(56); check("t6_out_e56", int'(out), 1);
    at_edge(57); check("t6_out_e57", int'(out), 0);
    at_edge(85); check("t6_queue_left", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", ecnt);
    $fatal(1, "watchdog");
  end

endmodule
